// File: rtl/idli_sqi_sram_m.sv
// SQI SRAM responder: decodes WRITE (0x02) / READ (0x03) with a 16-bit byte address
// and serves a byte array that auto-increments and wraps.
module idli_sqi_sram_m #(
   parameter int MEM_AW   = 10,
   parameter int RD_DUMMY = 2
) (
   input  logic       i_sram_gck,
   input  logic       i_sram_rst_n,
   input  logic       i_sram_sck_en,
   input  logic       i_sram_cs,
   input  logic [3:0] i_sram_data,
   output logic [3:0] o_sram_data,
   output logic       o_sram_data_oe,
   output logic       o_sram_busy,
   output logic       o_sram_bad_cmd
);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      DATA,
      IGNORE
   } state_t;

   localparam logic [1:0] DUMMY_LAST = 2'(RD_DUMMY - 1);

   state_t              state_reg, state_next;
   logic [1:0]          nib_reg, nib_next;
   logic [3:0]          cmd_hi_reg, cmd_hi_next;
   logic                rd_mode_reg, rd_mode_next;
   logic [15:0]         addr_reg, addr_next;
   logic [3:0]          wr_hi_reg, wr_hi_next;
   logic                oe_reg, oe_next;
   logic                bad_reg, bad_next;

   logic                beat;
   logic                wr_en;
   logic [MEM_AW-1:0]   wr_idx;
   logic [7:0]          wr_byte;
   logic                rd_en;
   logic [MEM_AW-1:0]   rd_idx;
   logic [7:0]          rd_buf_reg;
   logic [15:0]         addr_inc;

   logic [7:0]          mem [2**MEM_AW];

   assign beat     = ~i_sram_cs & i_sram_sck_en;
   assign addr_inc = addr_reg + 16'd1;

   always_comb begin
      state_next   = state_reg;
      nib_next     = nib_reg;
      cmd_hi_next  = cmd_hi_reg;
      rd_mode_next = rd_mode_reg;
      addr_next    = addr_reg;
      wr_hi_next   = wr_hi_reg;
      oe_next      = oe_reg;
      bad_next     = bad_reg;
      wr_en        = 1'b0;
      wr_idx       = addr_reg[MEM_AW-1:0];
      wr_byte      = {wr_hi_reg, i_sram_data};
      rd_en        = 1'b0;
      rd_idx       = addr_reg[MEM_AW-1:0];

      if (i_sram_cs) begin
         // Deselect wins over everything; a half-received write byte is dropped.
         state_next = IDLE;
         oe_next    = 1'b0;
         nib_next   = 2'd0;
      end else if (beat) begin
         case (state_reg)
            IDLE: begin
               cmd_hi_next = i_sram_data;
               nib_next    = 2'd0;
               state_next  = CMD;
            end
            CMD: begin
               nib_next = 2'd0;
               case ({cmd_hi_reg, i_sram_data})
                  8'h02: begin
                     state_next   = ADDR;
                     rd_mode_next = 1'b0;
                  end
                  8'h03: begin
                     state_next   = ADDR;
                     rd_mode_next = 1'b1;
                  end
                  default: begin
                     state_next = IGNORE;
                     bad_next   = 1'b1;
                  end
               endcase
            end
            ADDR: begin
               addr_next = {addr_reg[11:0], i_sram_data};
               nib_next  = nib_reg + 2'd1;
               if (nib_reg == 2'd3) begin
                  nib_next = 2'd0;
                  if (rd_mode_reg) begin
                     // Prefetch the first byte so it is ready by the first DATA cycle.
                     rd_en  = 1'b1;
                     rd_idx = addr_next[MEM_AW-1:0];
                     if (RD_DUMMY == 0) begin
                        state_next = DATA;
                        oe_next    = 1'b1;
                     end else begin
                        state_next = DUMMY;
                     end
                  end else begin
                     state_next = DATA;
                  end
               end
            end
            DUMMY: begin
               nib_next = nib_reg + 2'd1;
               if (nib_reg == DUMMY_LAST) begin
                  nib_next   = 2'd0;
                  state_next = DATA;
                  oe_next    = 1'b1;
               end
            end
            DATA: begin
               if (nib_reg[0]) begin
                  nib_next  = 2'd0;
                  addr_next = addr_inc;
                  if (rd_mode_reg) begin
                     rd_en  = 1'b1;
                     rd_idx = addr_inc[MEM_AW-1:0];
                  end else begin
                     wr_en = 1'b1;
                  end
               end else begin
                  nib_next = 2'd1;
                  if (!rd_mode_reg) begin
                     wr_hi_next = i_sram_data;
                  end
               end
            end
            IGNORE: begin
               oe_next = 1'b0;
            end
            default: begin
               state_next = IDLE;
               oe_next    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_sram_gck or negedge i_sram_rst_n) begin
      if (!i_sram_rst_n) begin
         state_reg   <= IDLE;
         nib_reg     <= 2'd0;
         cmd_hi_reg  <= 4'd0;
         rd_mode_reg <= 1'b0;
         addr_reg    <= 16'd0;
         wr_hi_reg   <= 4'd0;
         oe_reg      <= 1'b0;
         bad_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         nib_reg     <= nib_next;
         cmd_hi_reg  <= cmd_hi_next;
         rd_mode_reg <= rd_mode_next;
         addr_reg    <= addr_next;
         wr_hi_reg   <= wr_hi_next;
         oe_reg      <= oe_next;
         bad_reg     <= bad_next;
      end
   end

   // Storage is deliberately not reset so it maps onto block RAM.
   always_ff @(posedge i_sram_gck) begin
      if (wr_en && i_sram_rst_n) begin
         mem[wr_idx] <= wr_byte;
      end
      if (rd_en) begin
         rd_buf_reg <= mem[rd_idx];
      end
   end

   assign o_sram_data    = oe_reg ? (nib_reg[0] ? rd_buf_reg[3:0] : rd_buf_reg[7:4]) : 4'd0;
   assign o_sram_data_oe = oe_reg;
   assign o_sram_busy    = (state_reg != IDLE);
   assign o_sram_bad_cmd = bad_reg;

endmodule

// File: tb/tb_idli_sqi_sram_m.sv
// Directed bench for the SQI SRAM responder; a byte model feeds a queue of
// expected read nibbles that is drained as the responder drives the bus.
module tb_idli_sqi_sram_m;

   typedef logic [7:0] byte_q_t[$];

   logic       clk;
   logic       rst_n;
   logic       sck_en;
   logic       cs;
   logic [3:0] din;
   logic [3:0] dout;
   logic       oe;
   logic       busy;
   logic       bad_cmd;

   int checks = 0;
   int errors = 0;

   logic [7:0] model_mem [1024];
   logic [3:0] exp_q[$];

   idli_sqi_sram_m #(.MEM_AW(10), .RD_DUMMY(2)) dut (
      .i_sram_gck     (clk),
      .i_sram_rst_n   (rst_n),
      .i_sram_sck_en  (sck_en),
      .i_sram_cs      (cs),
      .i_sram_data    (din),
      .o_sram_data    (dout),
      .o_sram_data_oe (oe),
      .o_sram_busy    (busy),
      .o_sram_bad_cmd (bad_cmd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic cs_v, input logic en_v, input logic [3:0] d);
      @(negedge clk);
      cs     = cs_v;
      sck_en = en_v;
      din    = d;
   endtask

   task automatic beat(input logic [3:0] d);
      step(1'b0, 1'b1, d);
   endtask

   task automatic addr_beats(input logic [15:0] a, input int gap_after);
      for (int i = 0; i < 4; i++) begin
         beat(a[15-4*i -: 4]);
         if (i == gap_after) begin
            for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 4'h0);
         end
      end
   endtask

   task automatic end_txn();
      step(1'b1, 1'b0, 4'h0);
      @(negedge clk);
      check("idle_busy", {7'd0, busy}, 8'd0);
      check("idle_oe", {7'd0, oe}, 8'd0);
   endtask

   task automatic do_write(input logic [15:0] a, input byte_q_t bytes);
      beat(4'h0);
      beat(4'h2);
      addr_beats(a, -1);
      for (int i = 0; i < bytes.size(); i++) begin
         beat(bytes[i][7:4]);
         beat(bytes[i][3:0]);
         model_mem[10'(a + 16'(i))] = bytes[i];
      end
   endtask

   task automatic rd_nib(input string tag);
      logic [3:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      check({tag, "_oe"}, {7'd0, oe}, 8'd1);
      check(tag, {4'd0, dout}, {4'd0, e});
      cs     = 1'b0;
      sck_en = 1'b1;
      din    = 4'($urandom_range(0, 15));
   endtask

   task automatic start_read(input logic [15:0] a, input int nbytes, input int gap_addr);
      for (int i = 0; i < nbytes; i++) begin
         exp_q.push_back(model_mem[10'(a + 16'(i))][7:4]);
         exp_q.push_back(model_mem[10'(a + 16'(i))][3:0]);
      end
      beat(4'h0);
      beat(4'h3);
      addr_beats(a, gap_addr);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("dummy_oe", {7'd0, oe}, 8'd0);
         cs = 1'b0; sck_en = 1'b1; din = 4'h0;
      end
   endtask

   task automatic do_read(input string tag, input logic [15:0] a, input int nbytes,
                          input int gap_addr, input bit gap_data);
      start_read(a, nbytes, gap_addr);
      for (int k = 0; k < 2 * nbytes; k++) begin
         rd_nib(tag);
         if (gap_data && k < 2 * nbytes - 1) begin
            for (int g = 0; g < 3; g++) begin
               step(1'b0, 1'b0, 4'h0);
               check({tag, "_gap_oe"}, {7'd0, oe}, 8'd1);
               check({tag, "_gap"}, {4'd0, dout}, {4'd0, exp_q[0]});
            end
         end
      end
      end_txn();
   endtask

   initial begin
      rst_n  = 1'b0;
      cs     = 1'b1;
      sck_en = 1'b0;
      din    = 4'h0;
      repeat (3) @(negedge clk);
      check("rst_data", {4'd0, dout}, 8'd0);
      check("rst_oe", {7'd0, oe}, 8'd0);
      check("rst_busy", {7'd0, busy}, 8'd0);
      check("rst_bad", {7'd0, bad_cmd}, 8'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Write then read at 0x1234.
      do_write(16'h1234, '{8'hA5, 8'h3C});
      end_txn();
      do_read("wr_rd", 16'h1234, 2, -1, 1'b0);

      // Burst with wrap of the storage index at 2^10.
      do_write(16'h03FF, '{8'h11, 8'h22, 8'h33});
      end_txn();
      do_read("wrap", 16'h03FF, 3, -1, 1'b0);
      model_mem[0] = 8'h22;
      do_read("alias", 16'h0400, 1, -1, 1'b0);

      // SCK gating mid-address and between data nibbles.
      do_read("gated", 16'h1234, 2, 1, 1'b1);

      // Unrecognised command.
      beat(4'h0);
      beat(4'h5);
      for (int i = 0; i < 8; i++) begin
         beat(4'($urandom_range(0, 15)));
         check("bad_flag", {7'd0, bad_cmd}, 8'd1);
         check("bad_oe", {7'd0, oe}, 8'd0);
         check("bad_busy", {7'd0, busy}, 8'd1);
      end
      end_txn();
      check("bad_sticky", {7'd0, bad_cmd}, 8'd1);
      do_read("after_bad", 16'h1234, 2, -1, 1'b0);
      check("bad_sticky2", {7'd0, bad_cmd}, 8'd1);

      // Abort: partial byte discarded, CS pulse in ADDR returns to IDLE.
      do_write(16'h0011, '{8'hEE});
      end_txn();
      do_write(16'h0010, '{8'h77});
      beat(4'h9);
      end_txn();
      beat(4'h0);
      beat(4'h2);
      beat(4'h0);
      beat(4'h0);
      @(negedge clk);
      check("addr_busy", {7'd0, busy}, 8'd1);
      cs = 1'b1; sck_en = 1'b0;
      @(negedge clk);
      check("abort_busy", {7'd0, busy}, 8'd0);
      do_read("abort", 16'h0010, 2, -1, 1'b0);

      // Asynchronous reset during a read data phase.
      start_read(16'h03FF, 3, -1);
      rd_nib("pre_rst");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_oe", {7'd0, oe}, 8'd0);
      check("arst_busy", {7'd0, busy}, 8'd0);
      check("arst_bad", {7'd0, bad_cmd}, 8'd0);
      check("arst_data", {4'd0, dout}, 8'd0);
      exp_q.delete();
      cs = 1'b1; sck_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      do_read("post_rst", 16'h03FF, 3, -1, 1'b0);
      do_read("post_rst2", 16'h1234, 2, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/idli_sqi_sram_m.md
Name: idli_sqi_sram_m

Overview:
- Responder end of the SQI memory interface: a synthesisable SQI SRAM that receives command, address and data nibbles from the SQI initiator and returns read data in sequential mode.
- Used as the on-bench and FPGA-prototype memory behind the controller.
- Decodes WRITE (0x02) and READ (0x03) with a 16-bit byte address; all other commands are ignored.
- Storage is a byte array; the address auto-increments per byte and wraps.

Parameters:
MEM_AW, 10, log2 of storage bytes; the 16-bit wire address is taken modulo 2^MEM_AW.
RD_DUMMY, 2, dummy nibble count between address and read data (READ only).

Ports:
i_sram_gck  in  1  system clock; the initiator's SCK is a gated copy of this clock.
i_sram_rst_n  in  1  asynchronous active-low reset.
i_sram_sck_en  in  1  high in cycles where the initiator pulses SCK; the bus is sampled only when high.
i_sram_cs  in  1  chip select, high = deselected, low = selected.
i_sram_data  in  4  nibble from the initiator, MSB nibble first.
o_sram_data  out  4  read nibble to the initiator.
o_sram_data_oe  out  1  high when the responder drives the bus.
o_sram_busy  out  1  high while a transaction is in progress (state != IDLE).
o_sram_bad_cmd  out  1  sticky flag, set on an unrecognised command byte, cleared only by reset.

Behaviour:
- One clock and one reset: i_sram_gck, with asynchronous active-low i_sram_rst_n.
- Reset values: state IDLE, o_sram_data 0, o_sram_data_oe 0, o_sram_busy 0, o_sram_bad_cmd 0. Storage is not reset.
- A "beat" is a rising gck edge with i_sram_cs==0 and i_sram_sck_en==1. Only beats advance the FSM or capture data.
- i_sram_cs==1 at any rising edge: next state is IDLE, oe deasserts, and any partial write byte is discarded. This takes priority over all other events.
- Nibble counter: 2 bits, cleared on entering each state.

States:
- IDLE: the first beat captures the command high nibble and moves to CMD.
- CMD: the second beat completes the command byte.
  - 0x02: go to ADDR, mode = write.
  - 0x03: go to ADDR, mode = read.
  - Otherwise: go to IGNORE and set bad_cmd.
- ADDR: 4 beats shift a 16-bit address, MSB nibble first. On the 4th beat:
  - WRITE: go to DATA.
  - READ: go to DUMMY and load the read buffer with mem[addr mod 2^MEM_AW] on the next edge.
- DUMMY: RD_DUMMY beats, then go to DATA. oe rises on the edge that completes the last dummy beat, so it is high during the first DATA cycle.
- DATA write:
  - Beat 0 latches the high nibble.
  - Beat 1 writes {hi, lo} to mem[addr] on that edge and increments addr.
  - Repeats until CS goes high.
- DATA read:
  - o_sram_data = buffer[7:4] for the first nibble and buffer[3:0] for the second.
  - On the beat that consumes the low nibble: addr increments and the buffer reloads from mem[addr+1] on the same edge, so back-to-back bytes need no gap.
  - o_sram_data is a registered or buffer-mux output, stable for the whole cycle in which the initiator samples it.
- IGNORE: no storage access, oe=0; exit only via CS high.
- Address wrap: addr is 16 bits and wraps 0xFFFF -> 0x0000. The storage index is addr[MEM_AW-1:0], so storage aliases at 2^MEM_AW.
- Gaps: i_sram_sck_en low with CS low (initiator gating SCK) holds all state and outputs.
- Read-after-write ordering:
  - A write beat and a read-buffer load to the same byte cannot occur in the same transaction.
  - Across transactions, a READ returns data written by any earlier completed write beat.
- When oe=0, o_sram_data is 0.
- Asynchronous reset mid-transaction returns to IDLE immediately, and no write occurs on that edge.

Test Plan:
- Write then read: write nibbles 0,2 / 1,2,3,4 / A,5,3,C at addr 0x1234; CS high; read 0,3 / 1,2,3,4 / 2 dummy -> o_sram_data A,5,3,C with oe high from the first DATA cycle; busy low after CS.
- Burst and wrap (MEM_AW=10): write 3 bytes 11,22,33 at addr 0x03FF -> mem[0x3FF]=11, mem[0x000]=22, mem[0x001]=33; read 3 bytes from 0x03FF returns 1,1,2,2,3,3 with no idle cycles.
- SCK gating: READ with i_sram_sck_en low for 3 cycles mid-address and between data nibbles -> same data as the ungated run, and o_sram_data holds during gaps.
- Bad command: command 0x05 followed by 8 beats -> bad_cmd=1 and sticky, oe stays 0, memory unchanged; a next valid READ succeeds.
- Abort: WRITE at 0x0010 with byte 77, then high nibble 9 followed by CS high -> mem[0x10]=77, mem[0x11] unchanged; a CS pulse mid-ADDR returns to IDLE.
- Reset: assert rst_n low during DATA read -> oe=0, busy=0, and bad_cmd=0 in the same cycle; previously written bytes remain readable.
